// File: rtl/pipe_add_sub.sv
// Pipelined add/sub/inc/dec engine: one CHUNK-bit slice per stage, carry registered stage to stage.
// Latency: STAGES = WIDTH/CHUNK cycles from input accept to out_valid, one op per cycle throughput.
// Backpressure: global stall, every stage holds while out_valid && !out_ready; in_ready = !out_valid || out_ready.
module pipe_add_sub #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8,
  parameter int unsigned STEP  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);

  localparam int unsigned STAGES = WIDTH / CHUNK;
  localparam int unsigned LAST   = STAGES - 1;

  // Per-stage registers. A and effective B travel with the op so upper
  // slices are still available when their stage comes up; lower result
  // slices accumulate in r_q as they are resolved.
  logic             vld_q [STAGES];
  logic [WIDTH-1:0] a_q   [STAGES];
  logic [WIDTH-1:0] b_q   [STAGES];
  logic [WIDTH-1:0] r_q   [STAGES];
  logic             c_q   [STAGES];
  logic             ovf_q;

  // Stage inputs: stage 0 from the ports, stage k from stage k-1.
  logic             vld_in [STAGES];
  logic [WIDTH-1:0] a_in   [STAGES];
  logic [WIDTH-1:0] b_in   [STAGES];
  logic [WIDTH-1:0] r_in   [STAGES];
  logic             c_in   [STAGES];

  // Next-state values produced by each stage's slice adder.
  logic [CHUNK:0]   slice_sum [STAGES];
  logic [WIDTH-1:0] r_d       [STAGES];
  logic             c_d       [STAGES];
  logic             ovf_d;

  logic [WIDTH-1:0] b_sel;
  logic [WIDTH-1:0] b_eff;
  logic             cin0;
  logic             advance;

  // Operand prep: pick B or STEP, then invert with carry-in 1 for subtraction.
  always_comb begin
    b_sel = op[1] ? WIDTH'(STEP) : b;
    b_eff = op[0] ? ~b_sel : b_sel;
    cin0  = op[0];
  end

  // Wire each stage to its source: ports for stage 0, previous registers otherwise.
  always_comb begin
    vld_in[0] = in_valid;
    a_in[0]   = a;
    b_in[0]   = b_eff;
    r_in[0]   = '0;
    c_in[0]   = cin0;
    for (int k = 1; k < STAGES; k++) begin
      vld_in[k] = vld_q[k-1];
      a_in[k]   = a_q[k-1];
      b_in[k]   = b_q[k-1];
      r_in[k]   = r_q[k-1];
      c_in[k]   = c_q[k-1];
    end
  end

  // Slice adders: stage k resolves bits [k*CHUNK +: CHUNK] and drops them into the partial result.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      slice_sum[k] = {1'b0, a_in[k][k*CHUNK +: CHUNK]}
                   + {1'b0, b_in[k][k*CHUNK +: CHUNK]}
                   + {{CHUNK{1'b0}}, c_in[k]};
      r_d[k] = r_in[k];
      r_d[k][k*CHUNK +: CHUNK] = slice_sum[k][CHUNK-1:0];
      c_d[k] = slice_sum[k][CHUNK];
    end
    // Carry into the MSB is recovered from the MSB sum bit and its operands.
    ovf_d = (a_in[LAST][WIDTH-1] ^ b_in[LAST][WIDTH-1] ^ slice_sum[LAST][CHUNK-1])
          ^ slice_sum[LAST][CHUNK];
  end

  // Pipeline registers: cleared asynchronously, all advance together or all hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        vld_q[k] <= 1'b0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        r_q[k]   <= '0;
        c_q[k]   <= 1'b0;
      end
    end else if (advance) begin
      ovf_q <= ovf_d;
      for (int k = 0; k < STAGES; k++) begin
        vld_q[k] <= vld_in[k];
        a_q[k]   <= a_in[k];
        b_q[k]   <= b_in[k];
        r_q[k]   <= r_d[k];
        c_q[k]   <= c_d[k];
      end
    end
  end

  // Handshake and flags, all driven from the final-stage registers.
  always_comb begin
    out_valid = vld_q[LAST];
    advance   = !vld_q[LAST] || out_ready;
    in_ready  = advance;
    result    = r_q[LAST];
    cout      = c_q[LAST];
    ovf       = ovf_q;
    // Gated with valid so the cleared pipeline reports zero=0.
    zero      = vld_q[LAST] && (r_q[LAST] == '0);
    neg       = r_q[LAST][WIDTH-1];
  end

endmodule

// File: tb/tb_pipe_add_sub.sv
// Bench for pipe_add_sub: three widths (32/8, 16/16, 64/8) sharing stimulus.
// Directed corner ops, a randomized stalled stream against an arithmetic model,
// and asynchronous reset with ops in flight.
module tb_pipe_add_sub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid_s;
  logic        out_ready_s;
  logic [63:0] a_s;
  logic [63:0] b_s;
  logic [1:0]  op_s;
  int          sel;

  int checks = 0;
  int errors = 0;

  logic        ir32, ov32, co32, of32, z32, n32;
  logic [31:0] r32;
  logic        ir16, ov16, co16, of16, z16, n16;
  logic [15:0] r16;
  logic        ir64, ov64, co64, of64, z64, n64;
  logic [63:0] r64;

  pipe_add_sub #(.WIDTH(32), .CHUNK(8), .STEP(4)) u32 (
    .clk(clk), .rst(rst), .in_valid(in_valid_s && sel == 0), .in_ready(ir32),
    .a(a_s[31:0]), .b(b_s[31:0]), .op(op_s), .out_valid(ov32), .out_ready(out_ready_s),
    .result(r32), .cout(co32), .ovf(of32), .zero(z32), .neg(n32));

  pipe_add_sub #(.WIDTH(16), .CHUNK(16), .STEP(4)) u16 (
    .clk(clk), .rst(rst), .in_valid(in_valid_s && sel == 1), .in_ready(ir16),
    .a(a_s[15:0]), .b(b_s[15:0]), .op(op_s), .out_valid(ov16), .out_ready(out_ready_s),
    .result(r16), .cout(co16), .ovf(of16), .zero(z16), .neg(n16));

  pipe_add_sub #(.WIDTH(64), .CHUNK(8), .STEP(4)) u64 (
    .clk(clk), .rst(rst), .in_valid(in_valid_s && sel == 2), .in_ready(ir64),
    .a(a_s), .b(b_s), .op(op_s), .out_valid(ov64), .out_ready(out_ready_s),
    .result(r64), .cout(co64), .ovf(of64), .zero(z64), .neg(n64));

  // Observed outputs of the selected instance; o_fl = {cout, ovf, zero, neg}.
  logic        o_rdy, o_vld;
  logic [3:0]  o_fl;
  logic [63:0] o_res;
  always_comb begin
    case (sel)
      0: begin o_rdy = ir32; o_vld = ov32; o_fl = {co32, of32, z32, n32}; o_res = {32'b0, r32}; end
      1: begin o_rdy = ir16; o_vld = ov16; o_fl = {co16, of16, z16, n16}; o_res = {48'b0, r16}; end
      default: begin o_rdy = ir64; o_vld = ov64; o_fl = {co64, of64, z64, n64}; o_res = r64; end
    endcase
  end

  function automatic int w_of(int s);
    return (s == 0) ? 32 : (s == 1) ? 16 : 64;
  endfunction

  function automatic int lat_of(int s);
    return (s == 0) ? 4 : (s == 1) ? 1 : 8;
  endfunction

  // Arithmetic reference: returns {cout, ovf, zero, neg, result}.
  function automatic logic [67:0] ref_model(int w, logic [1:0] o, logic [63:0] x, logic [63:0] y);
    logic [64:0] m, full;
    logic [63:0] xa, yb, r;
    logic        c, v, sx, sy, sr;
    m  = (65'd1 << w) - 65'd1;
    xa = x & m[63:0];
    yb = (o[1] ? 64'd4 : y) & m[63:0];
    if (!o[0]) begin
      full = {1'b0, xa} + {1'b0, yb};
      c    = full[w];
    end else begin
      full = {1'b0, xa} - {1'b0, yb};
      c    = (xa >= yb);
    end
    r  = full[63:0] & m[63:0];
    sx = xa[w-1];
    sy = yb[w-1];
    sr = r[w-1];
    v  = o[0] ? (sx != sy && sr != sx) : (sx == sy && sr != sx);
    return {c, v, (r == 64'd0), sr, r};
  endfunction

  task automatic chk(string tag, logic [67:0] obs, logic [67:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One op into an empty pipe; checks acceptance, latency and result/flags.
  task automatic single_op(string tag, logic [1:0] o, logic [63:0] x, logic [63:0] y, logic [67:0] e);
    int cnt;
    @(negedge clk);
    out_ready_s = 1'b1;
    op_s = o; a_s = x; b_s = y; in_valid_s = 1'b1;
    #1 chk({tag, "_rdy"}, o_rdy, 1);
    @(posedge clk); #1;
    in_valid_s = 1'b0;
    a_s = {$urandom, $urandom}; b_s = {$urandom, $urandom}; op_s = 2'($urandom_range(0, 3));
    cnt = 1;
    while (!o_vld && cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk({tag, "_lat"}, cnt, lat_of(sel));
    chk({tag, "_res"}, {o_fl, o_res}, e);
    @(negedge clk);
  endtask

  // Fill the pipe with ops under stall, reset mid-cycle, then prove a clean restart.
  task automatic reset_inflight(string tag);
    int          guard;
    logic [63:0] x, y;
    logic [1:0]  o;
    @(negedge clk);
    out_ready_s = 1'b0;
    for (int i = 0; i < 3; i++) begin
      op_s = 2'($urandom_range(0, 3)); a_s = {$urandom, $urandom}; b_s = {$urandom, $urandom};
      in_valid_s = 1'b1;
      @(negedge clk);
    end
    in_valid_s = 1'b0;
    guard = 0;
    while (!o_vld && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk({tag, "_fill"}, o_vld, 1);
    #2 rst = 1'b1;
    #1;
    chk({tag, "_async_vld"}, o_vld, 0);
    chk({tag, "_async_out"}, {o_fl, o_res}, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    out_ready_s = 1'b1;
    #1 chk({tag, "_rdy"}, o_rdy, 1);
    guard = 0;
    repeat (12) begin
      @(negedge clk);
      if (o_vld) guard++;
    end
    chk({tag, "_stale"}, guard, 0);
    o = 2'($urandom_range(0, 3)); x = {$urandom, $urandom}; y = {$urandom, $urandom};
    single_op({tag, "_post"}, o, x, y, ref_model(w_of(sel), o, x, y));
  endtask

  logic [67:0] exp_q[$];
  logic [67:0] held;
  logic        stall_prev;
  int          sent, recv, cyc;

  initial begin
    rst = 1'b1; in_valid_s = 1'b0; out_ready_s = 1'b0;
    a_s = '0; b_s = '0; op_s = 2'b00; sel = 0;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      chk("reset_vld", o_vld, 0);
      chk("reset_out", {o_fl, o_res}, 0);
    end
    sel = 0;
    @(negedge clk);
    rst = 1'b0;
    #1 chk("reset_rdy", o_rdy, 1);

    // 32-bit directed corners; expected {cout,ovf,zero,neg,result}.
    single_op("add_ff_1",   2'b00, 64'h0000_00FF, 64'h1,          {4'b0000, 64'h0000_0100});
    single_op("sub_5_5",    2'b01, 64'd5,         64'd5,          {4'b1010, 64'h0});
    single_op("sub_3_5",    2'b01, 64'd3,         64'd5,          {4'b0001, 64'hFFFF_FFFE});
    single_op("add_ovf",    2'b00, 64'h7FFF_FFFF, 64'h1,          {4'b0101, 64'h8000_0000});
    single_op("add_wrap",   2'b00, 64'hFFFF_FFFF, 64'h1,          {4'b1010, 64'h0});
    single_op("inc_1000",   2'b10, 64'h0000_1000, 64'hDEAD_BEEF,  {4'b0000, 64'h0000_1004});
    single_op("dec_2",      2'b11, 64'h0000_0002, 64'hDEAD_BEEF,  {4'b0001, 64'hFFFF_FFFE});

    // Random stream with gaps and pseudo-random backpressure.
    sent = 0; recv = 0; cyc = 0; stall_prev = 1'b0; held = '0;
    @(negedge clk);
    while (recv < 16 && cyc < 1000) begin
      if (stall_prev) begin
        chk("hold_vld", o_vld, 1);
        chk("hold_dat", {o_fl, o_res}, held);
      end
      out_ready_s = ($urandom_range(0, 2) != 0);
      if (sent < 16 && $urandom_range(0, 3) != 0) begin
        in_valid_s = 1'b1;
        op_s = 2'($urandom_range(0, 3));
        a_s = {32'b0, $urandom};
        b_s = {32'b0, $urandom};
      end else begin
        in_valid_s = 1'b0;
      end
      #1;
      chk("in_ready_eq", o_rdy, !o_vld || out_ready_s);
      if (in_valid_s && o_rdy) begin
        exp_q.push_back(ref_model(32, op_s, a_s, b_s));
        sent++;
      end
      if (o_vld && out_ready_s) begin
        chk("stream_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) chk("stream_res", {o_fl, o_res}, exp_q.pop_front());
        recv++;
      end
      stall_prev = o_vld && !out_ready_s;
      held = {o_fl, o_res};
      @(negedge clk);
      cyc++;
    end
    in_valid_s = 1'b0;
    chk("stream_count", recv, 16);
    chk("stream_left", exp_q.size(), 0);

    reset_inflight("rst32");

    // 16-bit, single-stage instance.
    sel = 1;
    single_op("w16_wrap", 2'b00, 64'hFFFF, 64'h1, ref_model(16, 2'b00, 64'hFFFF, 64'h1));
    single_op("w16_dec",  2'b11, 64'h0,    64'hBEEF, {4'b0001, 64'hFFFC});
    reset_inflight("rst16");

    // 64-bit, eight-stage instance.
    sel = 2;
    single_op("w64_wrap", 2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, {4'b1010, 64'h0});
    single_op("w64_ovf",  2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, {4'b0101, 64'h8000_0000_0000_0000});
    reset_inflight("rst64");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
